// File: rtl/cc_psr.sv
// Condition-code / processor status register: holds ALU flags, evaluates branch
// conditions with same-cycle forwarding, and keeps a saturating overflow-event count.
module cc_psr #(
  parameter int DATAWIDTH_COND    = 4,
  parameter int DATAWIDTH_OVCOUNT = 8
) (
  input  logic                         CC_PSR_CLOCK_50,
  input  logic                         CC_PSR_RESET_InHigh,
  input  logic                         CC_PSR_aluValid_InHigh,
  input  logic                         CC_PSR_setFlags_InLow,
  input  logic                         CC_PSR_overflow_InLow,
  input  logic                         CC_PSR_carry_InLow,
  input  logic                         CC_PSR_negative_InLow,
  input  logic                         CC_PSR_zero_InLow,
  input  logic [DATAWIDTH_COND-1:0]    CC_PSR_cond_InBUS,
  input  logic                         CC_PSR_evalReq_InHigh,
  input  logic                         CC_PSR_ovClear_InHigh,
  output logic [3:0]                   CC_PSR_flags_OutBUS,
  output logic                         CC_PSR_evalValid_OutHigh,
  output logic                         CC_PSR_taken_OutHigh,
  output logic                         CC_PSR_illegal_OutHigh,
  output logic [DATAWIDTH_OVCOUNT-1:0] CC_PSR_ovCount_OutBUS
);

  logic [3:0]                   flags_q;
  logic                         eval_valid_q;
  logic                         taken_q;
  logic                         illegal_q;
  logic [DATAWIDTH_OVCOUNT-1:0] ov_count_q;

  logic       update;
  logic [3:0] new_flags;
  logic [3:0] eval_flags;
  logic       taken_d;
  logic       illegal_d;

  assign update    = CC_PSR_aluValid_InHigh & ~CC_PSR_setFlags_InLow;
  assign new_flags = {~CC_PSR_negative_InLow, ~CC_PSR_zero_InLow,
                      ~CC_PSR_overflow_InLow, ~CC_PSR_carry_InLow};

  // Forward the incoming flags so a branch paired with a cc-setting op sees them.
  assign eval_flags = update ? new_flags : flags_q;

  // flags layout is {N,Z,V,C}
  always_comb begin
    taken_d   = 1'b0;
    illegal_d = 1'b0;
    case (CC_PSR_cond_InBUS)
      DATAWIDTH_COND'(4'b0000): taken_d = 1'b0;
      DATAWIDTH_COND'(4'b0001): taken_d = eval_flags[2];
      DATAWIDTH_COND'(4'b0101): taken_d = eval_flags[0];
      DATAWIDTH_COND'(4'b0110): taken_d = eval_flags[3];
      DATAWIDTH_COND'(4'b0111): taken_d = eval_flags[1];
      DATAWIDTH_COND'(4'b1000): taken_d = 1'b1;
      default:                  illegal_d = 1'b1;
    endcase
  end

  always_ff @(posedge CC_PSR_CLOCK_50) begin
    if (CC_PSR_RESET_InHigh) begin
      flags_q      <= 4'b0000;
      eval_valid_q <= 1'b0;
      taken_q      <= 1'b0;
      illegal_q    <= 1'b0;
      ov_count_q   <= '0;
    end else begin
      if (update)
        flags_q <= new_flags;
      eval_valid_q <= CC_PSR_evalReq_InHigh;
      if (CC_PSR_evalReq_InHigh) begin
        taken_q   <= taken_d;
        illegal_q <= illegal_d;
      end
      // Clear has priority; the counter sticks at all-ones instead of wrapping.
      if (CC_PSR_ovClear_InHigh)
        ov_count_q <= '0;
      else if (update && !CC_PSR_overflow_InLow && (ov_count_q != '1))
        ov_count_q <= ov_count_q + 1'b1;
    end
  end

  assign CC_PSR_flags_OutBUS      = flags_q;
  assign CC_PSR_evalValid_OutHigh = eval_valid_q;
  assign CC_PSR_taken_OutHigh     = taken_q;
  assign CC_PSR_illegal_OutHigh   = illegal_q;
  assign CC_PSR_ovCount_OutBUS    = ov_count_q;

endmodule

// File: tb/tb_cc_psr.sv
// Randomized self-checking bench for cc_psr against a cycle-level behavioural model,
// plus directed scenarios for reset, forwarding, illegal codes and saturation.
module tb_cc_psr;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       alu_valid = 1'b0;
  logic       set_flags_n = 1'b1;
  logic       ov_n = 1'b1;
  logic       carry_n = 1'b1;
  logic       neg_n = 1'b1;
  logic       zero_n = 1'b1;
  logic [3:0] cond = 4'd0;
  logic       eval_req = 1'b0;
  logic       ov_clear = 1'b0;

  logic [3:0] flags;
  logic       eval_valid;
  logic       taken;
  logic       illegal;
  logic [7:0] ov_count;

  int compared   = 0;
  int mismatched = 0;

  // Reference model state, kept as plain booleans and an unbounded integer count.
  bit m_n, m_z, m_v, m_c;
  bit m_valid, m_taken, m_illegal;
  int m_count;

  always #5 clk = ~clk;

  cc_psr dut (
    .CC_PSR_CLOCK_50          (clk),
    .CC_PSR_RESET_InHigh      (rst),
    .CC_PSR_aluValid_InHigh   (alu_valid),
    .CC_PSR_setFlags_InLow    (set_flags_n),
    .CC_PSR_overflow_InLow    (ov_n),
    .CC_PSR_carry_InLow       (carry_n),
    .CC_PSR_negative_InLow    (neg_n),
    .CC_PSR_zero_InLow        (zero_n),
    .CC_PSR_cond_InBUS        (cond),
    .CC_PSR_evalReq_InHigh    (eval_req),
    .CC_PSR_ovClear_InHigh    (ov_clear),
    .CC_PSR_flags_OutBUS      (flags),
    .CC_PSR_evalValid_OutHigh (eval_valid),
    .CC_PSR_taken_OutHigh     (taken),
    .CC_PSR_illegal_OutHigh   (illegal),
    .CC_PSR_ovCount_OutBUS    (ov_count)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  function automatic void modelStep(input bit r, input bit v, input bit sn, input bit o_n,
                                    input bit c_n, input bit n_n, input bit z_n,
                                    input int cc, input bit req, input bit clr);
    bit upd, fn, fz, fv, fc;
    if (r) begin
      {m_n, m_z, m_v, m_c} = 4'b0000;
      m_valid = 0; m_taken = 0; m_illegal = 0;
      m_count = 0;
      return;
    end
    upd = v && !sn;
    fn = upd ? !n_n : m_n;
    fz = upd ? !z_n : m_z;
    fv = upd ? !o_n : m_v;
    fc = upd ? !c_n : m_c;
    m_valid = req;
    if (req) begin
      m_illegal = 0;
      if (cc == 0)      m_taken = 0;
      else if (cc == 1) m_taken = fz;
      else if (cc == 5) m_taken = fc;
      else if (cc == 6) m_taken = fn;
      else if (cc == 7) m_taken = fv;
      else if (cc == 8) m_taken = 1;
      else begin m_taken = 0; m_illegal = 1; end
    end
    m_n = fn; m_z = fz; m_v = fv; m_c = fc;
    if (clr)                m_count = 0;
    else if (upd && !o_n)   m_count = (m_count >= 255) ? 255 : m_count + 1;
  endfunction

  // Drive one cycle of inputs, advance the model and compare every output.
  task automatic applyStimulus(input bit r, input bit v, input bit sn, input bit o_n,
                               input bit c_n, input bit n_n, input bit z_n,
                               input logic [3:0] cc, input bit req, input bit clr);
    @(negedge clk);
    rst = r; alu_valid = v; set_flags_n = sn; ov_n = o_n; carry_n = c_n;
    neg_n = n_n; zero_n = z_n; cond = cc; eval_req = req; ov_clear = clr;
    @(posedge clk);
    #1;
    modelStep(r, v, sn, o_n, c_n, n_n, z_n, int'(cc), req, clr);
    checkOutput("flags",    32'(flags),      32'({m_n, m_z, m_v, m_c}));
    checkOutput("valid",    32'(eval_valid), 32'(m_valid));
    checkOutput("taken",    32'(taken),      32'(m_taken));
    checkOutput("illegal",  32'(illegal),    32'(m_illegal));
    checkOutput("ov_count", 32'(ov_count),   32'(m_count));
  endtask

  task automatic idle();
    applyStimulus(0, 0, 1, 1, 1, 1, 1, 4'd0, 0, 0);
  endtask

  initial begin
    m_n = 0; m_z = 0; m_v = 0; m_c = 0;
    m_valid = 0; m_taken = 0; m_illegal = 0; m_count = 0;

    applyStimulus(1, 0, 1, 1, 1, 1, 1, 4'd0, 0, 0);
    applyStimulus(1, 0, 1, 1, 1, 1, 1, 4'd0, 0, 0);
    checkOutput("reset_flags", 32'(flags), 32'h0);
    checkOutput("reset_count", 32'(ov_count), 32'h0);

    // Zero-only update lands as Z set.
    applyStimulus(0, 1, 0, 1, 1, 1, 0, 4'd0, 0, 0);
    checkOutput("z_update_flags", 32'(flags), 32'h4);
    checkOutput("z_update_count", 32'(ov_count), 32'h0);

    // setFlags high blocks the update even with all flag inputs asserted.
    applyStimulus(0, 1, 1, 0, 0, 0, 0, 4'd0, 0, 0);
    checkOutput("blocked_flags", 32'(flags), 32'h4);

    // Branch on C paired with the op that sets C.
    applyStimulus(0, 1, 0, 1, 0, 1, 1, 4'b0101, 1, 0);
    checkOutput("fwd_valid", 32'(eval_valid), 32'h1);
    checkOutput("fwd_taken", 32'(taken), 32'h1);
    checkOutput("fwd_illegal", 32'(illegal), 32'h0);
    checkOutput("fwd_flags", 32'(flags), 32'h1);

    applyStimulus(0, 0, 1, 1, 1, 1, 1, 4'b1010, 1, 0);
    checkOutput("illegal_valid", 32'(eval_valid), 32'h1);
    checkOutput("illegal_taken", 32'(taken), 32'h0);
    checkOutput("illegal_flag", 32'(illegal), 32'h1);
    idle();
    checkOutput("hold_valid", 32'(eval_valid), 32'h0);
    checkOutput("hold_illegal", 32'(illegal), 32'h1);

    // Back-to-back requests: always then never.
    applyStimulus(0, 0, 1, 1, 1, 1, 1, 4'b1000, 1, 0);
    checkOutput("always_taken", 32'(taken), 32'h1);
    applyStimulus(0, 0, 1, 1, 1, 1, 1, 4'b0000, 1, 0);
    checkOutput("never_valid", 32'(eval_valid), 32'h1);
    checkOutput("never_taken", 32'(taken), 32'h0);

    // Reset wins over a coincident update, request and count event.
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 4'b1000, 1, 0);
    checkOutput("rst_win_flags", 32'(flags), 32'h0);
    checkOutput("rst_win_valid", 32'(eval_valid), 32'h0);
    checkOutput("rst_win_taken", 32'(taken), 32'h0);
    idle();
    checkOutput("rst_after_valid", 32'(eval_valid), 32'h0);

    // Saturation, then clear beating a simultaneous overflow update.
    for (int i = 0; i < 300; i++)
      applyStimulus(0, 1, 0, 0, 1, 1, 1, 4'd0, 0, 0);
    checkOutput("sat_count", 32'(ov_count), 32'd255);
    applyStimulus(0, 1, 0, 0, 1, 1, 1, 4'd0, 0, 0);
    checkOutput("sat_hold", 32'(ov_count), 32'd255);
    applyStimulus(0, 1, 0, 0, 1, 1, 1, 4'd0, 0, 1);
    checkOutput("clear_wins", 32'(ov_count), 32'd0);

    for (int i = 0; i < 1500; i++) begin
      logic [3:0] rc;
      rc = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 15))
                                        : ($urandom_range(0, 1) == 0 ? 4'd1 : 4'($urandom_range(5, 8)));
      applyStimulus($urandom_range(0, 49) == 0,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    rc, 1'($urandom_range(0, 1)), $urandom_range(0, 39) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
